// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: issues multiply/divide work to the shared units, stalls the
// front end until the result lands in HI/LO, and serves MTHI/MTLO/MFHI/MFLO.
module muldiv_ctrl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     rs_data,
    input  logic [WIDTH-1:0]     rt_data,
    output logic                 stall,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic [WIDTH-1:0]     rd_data,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 mul_signed,
    input  logic [2*WIDTH-1:0]   mul_z,
    output logic                 div_start,
    output logic                 div_signed,
    output logic [WIDTH-1:0]     div_dividend,
    output logic [WIDTH-1:0]     div_divisor,
    input  logic [WIDTH-1:0]     div_q,
    input  logic [WIDTH-1:0]     div_r,
    input  logic                 div_busy
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL_WAIT  = 3'd1,
        ST_DIV_START = 3'd2,
        ST_DIV_WAIT  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // The most negative value divided by -1 overflows; its result is fixed here.
    function automatic logic is_div_overflow(input logic [WIDTH-1:0] dividend,
                                             input logic [WIDTH-1:0] divisor);
        return (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               stall_s;
    logic               hi_we_s;
    logic               lo_we_s;
    logic [WIDTH-1:0]   hi_d_s;
    logic [WIDTH-1:0]   lo_d_s;
    logic               mul_latch_s;
    logic               div_latch_s;
    logic               div_start_next_s;
    logic               sign_clear_s;

    // Next-state, stall and HI/LO write decode.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        stall_s          = 1'b0;
        hi_we_s          = 1'b0;
        lo_we_s          = 1'b0;
        hi_d_s           = {WIDTH{1'b0}};
        lo_d_s           = {WIDTH{1'b0}};
        mul_latch_s      = 1'b0;
        div_latch_s      = 1'b0;
        div_start_next_s = 1'b0;
        sign_clear_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            stall_s      = 1'b1;
                            mul_latch_s  = 1'b1;
                            cnt_next_s   = CNT_W'(MUL_LAT);
                            state_next_s = ST_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            stall_s     = 1'b1;
                            div_latch_s = 1'b1;
                            if (rt_data == {WIDTH{1'b0}}) begin
                                hi_we_s      = 1'b1;
                                hi_d_s       = rs_data;
                                lo_we_s      = 1'b1;
                                lo_d_s       = {WIDTH{1'b1}};
                                state_next_s = ST_DONE;
                            end else if ((op == OP_DIV) && is_div_overflow(rs_data, rt_data)) begin
                                hi_we_s      = 1'b1;
                                hi_d_s       = {WIDTH{1'b0}};
                                lo_we_s      = 1'b1;
                                lo_d_s       = {1'b1, {(WIDTH-1){1'b0}}};
                                state_next_s = ST_DONE;
                            end else begin
                                div_start_next_s = 1'b1;
                                state_next_s     = ST_DIV_START;
                            end
                        end
                        OP_MTHI: begin
                            hi_we_s = 1'b1;
                            hi_d_s  = rs_data;
                        end
                        OP_MTLO: begin
                            lo_we_s = 1'b1;
                            lo_d_s  = rs_data;
                        end
                        OP_MFHI, OP_MFLO: begin
                            state_next_s = ST_IDLE;
                        end
                        default: begin
                            state_next_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL_WAIT: begin
                stall_s = 1'b1;
                if (cnt_r == CNT_W'(1)) begin
                    hi_we_s      = 1'b1;
                    hi_d_s       = mul_z[2*WIDTH-1:WIDTH];
                    lo_we_s      = 1'b1;
                    lo_d_s       = mul_z[WIDTH-1:0];
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DIV_START: begin
                stall_s      = 1'b1;
                state_next_s = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                stall_s = 1'b1;
                if (!div_busy) begin
                    hi_we_s      = 1'b1;
                    hi_d_s       = div_r;
                    lo_we_s      = 1'b1;
                    lo_d_s       = div_q;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DIV_WAIT;
                end
            end
            ST_DONE: begin
                // One unstalled cycle lets PC/IR move past the op so it is not re-issued.
                sign_clear_s = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Stall is held low while reset is asserted regardless of decode inputs.
    assign stall = stall_s & ~rst;

    // FSM state and multiply latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= {WIDTH{1'b0}};
            lo <= {WIDTH{1'b0}};
        end else begin
            if (hi_we_s) begin
                hi <= hi_d_s;
            end
            if (lo_we_s) begin
                lo <= lo_d_s;
            end
        end
    end

    // Multiplier operand registers and signedness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a      <= {WIDTH{1'b0}};
            mul_b      <= {WIDTH{1'b0}};
            mul_signed <= 1'b0;
        end else if (mul_latch_s) begin
            mul_a      <= rs_data;
            mul_b      <= rt_data;
            mul_signed <= (op == OP_MULT);
        end else if (sign_clear_s) begin
            mul_signed <= 1'b0;
        end
    end

    // Divider operand registers, signedness and the single-cycle start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_dividend <= {WIDTH{1'b0}};
            div_divisor  <= {WIDTH{1'b0}};
            div_signed   <= 1'b0;
            div_start    <= 1'b0;
        end else begin
            div_start <= div_start_next_s;
            if (div_latch_s) begin
                div_dividend <= rs_data;
                div_divisor  <= rt_data;
                div_signed   <= (op == OP_DIV);
            end else if (sign_clear_s) begin
                div_signed <= 1'b0;
            end
        end
    end

    // MFHI/MFLO read port.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        if (op_valid && (op == OP_MFHI)) begin
            rd_data = hi;
        end else if (op_valid && (op == OP_MFLO)) begin
            rd_data = lo;
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models and
// a HI/LO scoreboard popped when each stalled op completes.
module tb_muldiv_ctrl;

    localparam int W        = 32;
    localparam int DIV_CYC  = 33;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    logic           clk;
    logic           rst;
    logic           op_valid;
    logic [2:0]     op;
    logic [W-1:0]   rs_data;
    logic [W-1:0]   rt_data;
    logic           stall;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [W-1:0]   rd_data;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_signed;
    logic [2*W-1:0] mul_z;
    logic           div_start;
    logic           div_signed;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic [W-1:0]   div_q;
    logic [W-1:0]   div_r;
    logic           div_busy;

    int vectors;
    int errors;
    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];

    muldiv_ctrl #(.WIDTH(W), .MUL_LAT(1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
        .hi(hi), .lo(lo), .rd_data(rd_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_z(mul_z),
        .div_start(div_start), .div_signed(div_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_q(div_q), .div_r(div_r), .div_busy(div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle multiplier: product of sign- or zero-extended operands.
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    always_comb begin
        ext_a = mul_signed ? {{W{mul_a[W-1]}}, mul_a} : {{W{1'b0}}, mul_a};
        ext_b = mul_signed ? {{W{mul_b[W-1]}}, mul_b} : {{W{1'b0}}, mul_b};
        mul_z = ext_a * ext_b;
    end

    // Iterative divider model: busy for DIV_CYC cycles, results shown only when done.
    int           dv_cnt;
    logic [W-1:0] dv_q_hold;
    logic [W-1:0] dv_r_hold;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_busy <= 1'b0;
            dv_cnt   <= 0;
            div_q    <= 32'hDEAD_BEEF;
            div_r    <= 32'hDEAD_BEEF;
        end else if (div_start) begin
            div_busy <= 1'b1;
            dv_cnt   <= DIV_CYC;
            div_q    <= 32'hDEAD_BEEF;
            div_r    <= 32'hDEAD_BEEF;
            if (div_divisor == 32'd0) begin
                dv_q_hold <= 32'hFFFF_FFFF;
                dv_r_hold <= div_dividend;
            end else if (div_signed) begin
                dv_q_hold <= W'($signed(div_dividend) / $signed(div_divisor));
                dv_r_hold <= W'($signed(div_dividend) % $signed(div_divisor));
            end else begin
                dv_q_hold <= div_dividend / div_divisor;
                dv_r_hold <= div_dividend % div_divisor;
            end
        end else if (div_busy) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) begin
                div_busy <= 1'b0;
                div_q    <= dv_q_hold;
                div_r    <= dv_r_hold;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one stalling op, follow it to DONE, then compare against the scoreboard.
    task automatic run_op(input string tag, input logic [2:0] op_v,
                          input logic [W-1:0] rs_v, input logic [W-1:0] rt_v,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input int e_stall, input int e_starts,
                          input logic e_msig, input logic e_dsig, input bit chk_fall);
        int   cyc;
        int   stall_cyc;
        int   starts;
        int   busy_fall;
        bit   busy_seen;
        logic msig;
        logic dsig;
        exp_hi_q.push_back(e_hi);
        exp_lo_q.push_back(e_lo);
        op_valid = 1'b1;
        op       = op_v;
        rs_data  = rs_v;
        rt_data  = rt_v;
        cyc = 0; stall_cyc = 0; starts = 0; busy_fall = -1; busy_seen = 1'b0;
        msig = 1'b0; dsig = 1'b0;
        #1;
        while (stall === 1'b1 && cyc < 200) begin
            stall_cyc++;
            if (div_start === 1'b1) starts++;
            if (div_busy === 1'b1) busy_seen = 1'b1;
            else if (busy_seen && busy_fall < 0) busy_fall = cyc;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                msig = mul_signed;
                dsig = div_signed;
            end
        end
        check({tag, "_timeout"}, 64'(cyc < 200), 64'd1);
        if (e_stall >= 0) check({tag, "_stall_cycles"}, 64'(stall_cyc), 64'(e_stall));
        check({tag, "_div_starts"}, 64'(starts), 64'(e_starts));
        check({tag, "_mul_signed"}, 64'(msig), 64'(e_msig));
        check({tag, "_div_signed"}, 64'(dsig), 64'(e_dsig));
        if (chk_fall) check({tag, "_stall_after_busy"}, 64'(cyc), 64'(busy_fall + 1));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi_q.pop_front()));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo_q.pop_front()));
        op_valid = 1'b0;
        op       = OP_MULT;
        @(posedge clk);
        #1;
        check({tag, "_no_reissue"}, 64'(stall), 64'd0);
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        rst      = 1'b1;
        op_valid = 1'b1;
        op       = OP_MULT;
        rs_data  = 32'd5;
        rt_data  = 32'd7;
        #12;
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_mul_a", 64'(mul_a), 64'd0);
        check("reset_div_start", 64'(div_start), 64'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 2, 0, 1'b0, 1'b0, 1'b0);
        op_valid = 1'b1; op = OP_MFLO;
        #1 check("mflo_after_done", 64'(rd_data), 64'hFFFF_FFFE);
        op = OP_MFHI;
        #1 check("mfhi_after_done", 64'(rd_data), 64'h1);
        op_valid = 1'b0;
        @(posedge clk); #1;

        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2, 0, 1'b1, 1'b0, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 1, 1'b0, 1'b1, 1'b1);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1, 1, 1'b0, 1'b0, 1'b1);
        run_op("divu_by0", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1, 0, 1'b0, 1'b0, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1, 0, 1'b0, 1'b1, 1'b0);

        op_valid = 1'b1; op = OP_MTHI; rs_data = 32'h1111_2222;
        @(posedge clk); #1;
        op_valid = 1'b1; op = OP_DIV; rs_data = 32'd100; rt_data = 32'd3;
        repeat (6) @(posedge clk);
        #1;
        check("rst_pre_busy", 64'(div_busy), 64'd1);
        check("rst_pre_hi", 64'(hi), 64'h1111_2222);
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_div_start", 64'(div_start), 64'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        op_valid = 1'b1; op = OP_MTHI; rs_data = 32'hA5A5_A5A5;
        #1 check("mthi_no_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op = OP_MFHI;
        #1 check("mfhi_rd_data", 64'(rd_data), 64'hA5A5_A5A5);
        op = OP_MTLO; rs_data = 32'h5A5A_0F0F;
        @(posedge clk); #1;
        op = OP_MFLO;
        #1 check("mflo_rd_data", 64'(rd_data), 64'h5A5A_0F0F);
        check("mtlo_hi_kept", 64'(hi), 64'hA5A5_A5A5);
        op_valid = 1'b0;
        @(posedge clk); #1;

        check("scoreboard_empty", 64'(exp_hi_q.size() + exp_lo_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
